// File: rtl/pdl_ctl.sv
// CADR PDL buffer sequencer: pointer/index, one-entry posted write buffer with read
// bypass, and microcode/debug arbitration of the single synchronous PDL RAM port.
// Optional: define PDL_BOUNDS_TRAP_EN for the sticky pointer-wrap error flag pdl_err.
module pdl_ctl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic              srcpdltop,
  input  logic              srcpdlpop,
  input  logic              srcpdlidx,
  input  logic              srcpdlptr,
  input  logic              destpdltop,
  input  logic              destpdl_p,
  input  logic              destpdl_x,
  input  logic              destpdlp,
  input  logic              destpdlx,
  input  logic [DATA_W-1:0] ob,
  output logic [ADDR_W-1:0] pdl_addr,
  output logic              pdl_we,
  output logic [DATA_W-1:0] pdl_wdata,
  input  logic [DATA_W-1:0] pdl_rdata,
  output logic [DATA_W-1:0] pdl_q,
  output logic [ADDR_W-1:0] pdlptr,
  output logic [ADDR_W-1:0] pdlidx,
  output logic              stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              pdl_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DBG, ST_ACK} dbg_state_e;
  typedef enum logic [1:0] {Q_NONE, Q_HOLD, Q_RAM} q_sel_e;

  dbg_state_e        r_state;
  q_sel_e            r_q_sel;
  logic [DATA_W-1:0] r_q_hold;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_idx;
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_ack;

  logic              w_src_rd;
  logic              w_dest_data;
  logic              w_stall;
  logic              w_exec;
  logic              w_rd;
  logic              w_drain;
  logic              w_hit;
  logic              w_dbg_kill;
  logic              w_push_only;
  logic              w_pop_only;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_ptr_next;

  assign w_src_rd    = srcpdltop | srcpdlpop;
  assign w_dest_data = destpdltop | destpdl_p | destpdl_x;
  assign w_push_only = destpdl_p & ~srcpdlpop;
  assign w_pop_only  = srcpdlpop & ~destpdl_p;

  // A new data destination cannot be accepted while the previous one is still posted.
  assign w_stall   = step & ((r_state == ST_DBG) | (w_dest_data & r_wb_valid));
  assign w_exec    = step & ~w_stall;
  assign w_rd      = w_exec & w_src_rd;
  assign w_drain   = r_wb_valid & (r_state != ST_DBG) & ~w_rd;
  assign w_rd_addr = srcpdlpop ? r_ptr : r_idx;
  assign w_hit     = r_wb_valid & (r_wb_addr == w_rd_addr);
  assign w_dbg_kill = (r_state == ST_DBG) & dbg_we & r_wb_valid & (dbg_addr == r_wb_addr);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ptr_next = r_ptr;
    if (destpdlp)         w_ptr_next = ob[ADDR_W-1:0];
    else if (w_push_only) w_ptr_next = r_ptr + ADDR_W'(1);
    else if (w_pop_only)  w_ptr_next = r_ptr - ADDR_W'(1);
  end

  always_comb begin
    w_wr_addr = r_ptr;
    if (destpdl_x)        w_wr_addr = r_idx;
    else if (w_push_only) w_wr_addr = r_ptr + ADDR_W'(1);
  end

  always_comb begin
    pdl_addr  = '0;
    pdl_we    = 1'b0;
    pdl_wdata = '0;
    if (r_state == ST_DBG) begin
      pdl_addr  = dbg_addr;
      pdl_we    = dbg_we;
      pdl_wdata = dbg_wdata;
    end else if (w_drain) begin
      pdl_addr  = r_wb_addr;
      pdl_we    = 1'b1;
      pdl_wdata = r_wb_data;
    end else if (w_rd) begin
      pdl_addr  = w_rd_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_q_sel    <= Q_NONE;
      r_q_hold   <= '0;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_ack      <= 1'b0;
    end else begin
      if (w_exec) begin
        r_ptr <= w_ptr_next;
        if (destpdlx) r_idx <= ob[ADDR_W-1:0];
      end

      if (w_exec && w_dest_data) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= w_wr_addr;
        r_wb_data  <= ob;
      end else if (w_drain || w_dbg_kill) begin
        r_wb_valid <= 1'b0;
      end

      r_q_sel  <= Q_NONE;
      r_q_hold <= '0;
      if (w_exec) begin
        if (srcpdlptr) begin
          r_q_sel  <= Q_HOLD;
          r_q_hold <= DATA_W'(r_ptr);
        end else if (srcpdlidx) begin
          r_q_sel  <= Q_HOLD;
          r_q_hold <= DATA_W'(r_idx);
        end else if (w_src_rd) begin
          if (w_hit) begin
            r_q_sel  <= Q_HOLD;
            r_q_hold <= r_wb_data;
          end else begin
            r_q_sel  <= Q_RAM;
          end
        end
      end

      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: if (dbg_req && !step && !r_wb_valid) r_state <= ST_DBG;
        ST_DBG: begin
          r_state <= ST_ACK;
          r_ack   <= 1'b1;
        end
        ST_ACK:  if (!dbg_req) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pdl_q     = (r_q_sel == Q_RAM) ? pdl_rdata : r_q_hold;
  assign pdlptr    = r_ptr;
  assign pdlidx    = r_idx;
  assign stall     = w_stall;
  assign dbg_ack   = r_ack;
  assign dbg_rdata = r_ack ? pdl_rdata : '0;

`ifdef PDL_BOUNDS_TRAP_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_exec) begin
      if (destpdlp) r_err <= 1'b0;
      else if ((w_push_only && (&r_ptr)) || (w_pop_only && (r_ptr == '0))) r_err <= 1'b1;
    end
  end

  assign pdl_err = r_err;
`else
  assign pdl_err = 1'b0;
`endif

endmodule

// File: tb/tb_pdl_ctl.sv
// Bench for pdl_ctl: directed scenarios plus random instruction/debug traffic,
// scored against a logical PDL model (latest value written per address).
module tb_pdl_ctl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  localparam int S_NONE = 0, S_TOP = 1, S_POP = 2, S_IDX = 3, S_PTR = 4;
  localparam int D_NONE = 0, D_TOP = 1, D_PUSH = 2, D_X = 3, D_LDP = 4, D_LDX = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          step = 1'b0;
  logic          srcpdltop = 1'b0, srcpdlpop = 1'b0, srcpdlidx = 1'b0, srcpdlptr = 1'b0;
  logic          destpdltop = 1'b0, destpdl_p = 1'b0, destpdl_x = 1'b0;
  logic          destpdlp = 1'b0, destpdlx = 1'b0;
  logic [DW-1:0] ob = '0;
  logic [AW-1:0] pdl_addr;
  logic          pdl_we;
  logic [DW-1:0] pdl_wdata;
  logic [DW-1:0] pdl_rdata;
  logic [DW-1:0] pdl_q;
  logic [AW-1:0] pdlptr, pdlidx;
  logic          stall;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          pdl_err;

  pdl_ctl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .step(step),
    .srcpdltop(srcpdltop), .srcpdlpop(srcpdlpop), .srcpdlidx(srcpdlidx), .srcpdlptr(srcpdlptr),
    .destpdltop(destpdltop), .destpdl_p(destpdl_p), .destpdl_x(destpdl_x),
    .destpdlp(destpdlp), .destpdlx(destpdlx), .ob(ob),
    .pdl_addr(pdl_addr), .pdl_we(pdl_we), .pdl_wdata(pdl_wdata), .pdl_rdata(pdl_rdata),
    .pdl_q(pdl_q), .pdlptr(pdlptr), .pdlidx(pdlidx), .stall(stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .pdl_err(pdl_err)
  );

  always #5 clk = ~clk;

  // Synchronous PDL RAM with a bench-side preload port.
  logic [DW-1:0] ram [DEPTH];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en)       ram[ld_addr] <= ld_data;
    else if (pdl_we) ram[pdl_addr] <= pdl_wdata;
    pdl_rdata <= ram[pdl_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: logical PDL contents and registers.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr = 0, m_idx = 0;
  logic          m_err = 1'b0;

  typedef struct { int due; logic [DW-1:0] val; } q_exp_t;
  typedef struct { logic chk; logic [DW-1:0] val; } d_exp_t;
  q_exp_t q_exp[$];
  d_exp_t dbg_exp[$];

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: awaited event did not occur", name);
  endtask

  function automatic logic exp_err();
`ifdef PDL_BOUNDS_TRAP_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: compares pdl_q in the cycle after each executed step, and dbg_rdata on ack.
  always @(negedge clk) begin
    if (q_exp.size() > 0 && q_exp[0].due == cyc) begin
      check("pdl_q", pdl_q, q_exp[0].val);
      void'(q_exp.pop_front());
    end else if (q_exp.size() > 0 && q_exp[0].due < cyc) begin
      fail_now("pdl_q sample missed");
      void'(q_exp.pop_front());
    end
    if (dbg_ack) begin
      if (dbg_exp.size() == 0) fail_now("unsolicited dbg_ack");
      else begin
        if (dbg_exp[0].chk) check("dbg_rdata", dbg_rdata, dbg_exp[0].val);
        void'(dbg_exp.pop_front());
      end
    end
  end

  task automatic drive(input int src, input int dst, input logic [DW-1:0] obv, input logic stp);
    step = stp;
    srcpdltop = (src == S_TOP);  srcpdlpop = (src == S_POP);
    srcpdlidx = (src == S_IDX);  srcpdlptr = (src == S_PTR);
    destpdltop = (dst == D_TOP); destpdl_p = (dst == D_PUSH); destpdl_x = (dst == D_X);
    destpdlp = (dst == D_LDP);   destpdlx = (dst == D_LDX);
    ob = obv;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(S_NONE, D_NONE, '0, 1'b0);
    end
  endtask

  task automatic issue(input int src, input int dst, input logic [DW-1:0] obv,
                       output int stalls, output logic [AW-1:0] addr_seen);
    logic [DW-1:0] eq;
    int            nxt, wa;
    bit            ok;
    @(negedge clk);
    drive(src, dst, obv, 1'b1);
    stalls = 0; ok = 0; addr_seen = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!stall) begin ok = 1; break; end
      stalls++;
      @(negedge clk);
    end
    if (!ok) begin
      fail_now("step held by stall");
      drive(S_NONE, D_NONE, '0, 1'b0);
      return;
    end
    addr_seen = pdl_addr;
    case (src)
      S_TOP:   eq = m_mem[m_idx];
      S_POP:   eq = m_mem[m_ptr];
      S_IDX:   eq = DW'(m_idx);
      S_PTR:   eq = DW'(m_ptr);
      default: eq = '0;
    endcase
    q_exp.push_back('{cyc + 1, eq});
    wa = -1;
    if (dst == D_TOP)  wa = m_ptr;
    if (dst == D_PUSH) wa = (src == S_POP) ? m_ptr : (m_ptr + 1) % DEPTH;
    if (dst == D_X)    wa = m_idx;
    if (wa >= 0) m_mem[wa] = obv;
    if (dst == D_LDP) begin
      m_ptr = int'(obv[AW-1:0]);
      m_err = 1'b0;
    end else begin
      nxt = m_ptr + ((dst == D_PUSH) ? 1 : 0) - ((src == S_POP) ? 1 : 0);
      if (nxt < 0 || nxt >= DEPTH) m_err = 1'b1;
      m_ptr = (nxt + DEPTH) % DEPTH;
    end
    if (dst == D_LDX) m_idx = int'(obv[AW-1:0]);
    @(posedge clk);
    #1;
    check("pdlptr", pdlptr, m_ptr);
    check("pdlidx", pdlidx, m_idx);
    check("pdl_err", pdl_err, exp_err());
  endtask

  task automatic dbg_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat);
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    dbg_exp.push_back('{!we, m_mem[a]});
    if (we) m_mem[a] = d;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (dbg_ack) break;
    end
    if (!dbg_ack) fail_now("dbg_ack");
    dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " pdlptr"}, pdlptr, 0);
    check({tag, " pdlidx"}, pdlidx, 0);
    check({tag, " pdl_q"}, pdl_q, 0);
    check({tag, " stall"}, stall, 0);
    check({tag, " dbg_ack"}, dbg_ack, 0);
    check({tag, " pdl_we"}, pdl_we, 0);
    check({tag, " pdl_err"}, pdl_err, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(S_NONE, D_NONE, '0, 1'b0);
    dbg_req = 1'b0; dbg_we = 1'b0;
    reset_n = 1'b0;
    #1;
    reset_checks("reset");
    m_ptr = 0; m_idx = 0; m_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            st, st2, lat;
    logic [AW-1:0] a;
    logic [DW-1:0] v, saved;
    int            p0;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      v = $urandom;
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = v;
      m_mem[i] = v;
    end
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    reset_checks("power-on");
    @(negedge clk);
    reset_n = 1'b1;

    // Push then pop: value comes from the posted buffer.
    issue(S_NONE, D_LDP, 32'd5, st, a);
    issue(S_NONE, D_PUSH, 32'hAA, st, a);
    issue(S_POP, D_NONE, '0, st, a);
    check("pop restores ptr", pdlptr, 5);

    // Index write, idle drain, then read back from RAM.
    issue(S_NONE, D_LDX, 32'h3FF, st, a);
    issue(S_NONE, D_X, 32'h1234, st, a);
    idle(1);
    issue(S_TOP, D_NONE, '0, st, a);
    check("srcpdltop addr", a, 10'h3FF);

    // Back-to-back pushes: exactly one stall cycle, both words land in RAM.
    idle(2);
    p0 = m_ptr;
    issue(S_NONE, D_PUSH, 32'h1111_0001, st, a);
    issue(S_NONE, D_PUSH, 32'h2222_0002, st2, a);
    check("b2b stall cycles", st + st2, 1);
    idle(3);
    check("ram ptr+1", ram[(p0 + 1) % DEPTH], 32'h1111_0001);
    check("ram ptr+2", ram[(p0 + 2) % DEPTH], 32'h2222_0002);

    // Pop wrap 0 -> max; error flag (when enabled) held until pointer load.
    issue(S_NONE, D_LDP, 32'd0, st, a);
    issue(S_POP, D_NONE, '0, st, a);
    check("wrap ptr", pdlptr, 10'h3FF);
    idle(2);
    check("err held", pdl_err, exp_err());
    issue(S_NONE, D_PUSH, 32'hBEEF, st, a);
    issue(S_NONE, D_LDP, 32'd3, st, a);

    // Debug write, microcode read-back, debug read-back.
    idle(2);
    dbg_access(1'b1, 10'd7, 32'h55, lat);
    check("dbg write latency", lat, 2);
    issue(S_NONE, D_LDX, 32'd7, st, a);
    issue(S_TOP, D_NONE, '0, st, a);
    idle(1);
    dbg_access(1'b0, 10'd7, '0, lat);
    check("dbg read latency", lat, 2);

    // Step arriving during the debug access stalls one cycle and sees the debug write.
    issue(S_NONE, D_LDX, 32'd9, st, a);
    idle(2);
    fork
      dbg_access(1'b1, 10'd9, 32'h66, lat);
      begin
        @(negedge clk);
        issue(S_TOP, D_NONE, '0, st, a);
      end
    join
    check("dbg overlap stall", st, 1);
    check("dbg overlap latency", lat, 2);

    // Reset with a posted write pending: the write is lost.
    issue(S_NONE, D_LDX, 32'd20, st, a);
    idle(2);
    saved = m_mem[20];
    issue(S_NONE, D_X, 32'hDEAD_BEEF, st, a);
    apply_reset();
    m_mem[20] = saved;
    issue(S_NONE, D_LDX, 32'd20, st, a);
    issue(S_TOP, D_NONE, '0, st, a);

    // Reset in the middle of a debug access: no ack is issued.
    idle(2);
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd3;
    @(negedge clk);
    reset_n = 1'b0;
    dbg_req = 1'b0;
    m_ptr = 0; m_idx = 0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) reset_n = 1'b1;
      check("no ack after reset", dbg_ack, 0);
    end

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(1);
        dbg_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom, lat);
        check("rand dbg latency", lat, 2);
      end else begin
        int src, dst;
        src = $urandom_range(0, 4);
        dst = $urandom_range(0, 5);
        if (dst == D_LDP || dst == D_LDX)
          v = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 31))
                                          : DW'($urandom_range(DEPTH - 4, DEPTH - 1));
        else
          v = $urandom;
        issue(src, dst, v, st, a);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
    end
    idle(3);
    if (q_exp.size() != 0) fail_now("pdl_q scoreboard drained");
    if (dbg_exp.size() != 0) fail_now("dbg scoreboard drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pdl_ctl.md
Name: pdl_ctl

Overview:
- Sequences the CADR PDL buffer: maintains the PDL pointer and PDL index, and generates RAM address and write-enable from the decoded source/destination strobes.
- Posts destination writes through a one-entry write buffer, with read bypass.
- Arbitrates the single RAM port between microcode and the debug (bus) interface.
- Sits between the SOURCE decoder outputs and the PDL RAM.

Parameters:
ADDR_W, 10, PDL address / pointer / index width
DATA_W, 32, PDL word width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
step  in  1  microinstruction execute strobe; qualifies all src*/dest* inputs
srcpdltop  in  1  read PDL[index]
srcpdlpop  in  1  read PDL[pointer], then decrement pointer
srcpdlidx  in  1  read PDL index (zero-extended onto pdl_q)
srcpdlptr  in  1  read PDL pointer (zero-extended onto pdl_q)
destpdltop  in  1  write PDL[pointer]
destpdl_p  in  1  increment pointer, write PDL[new pointer]
destpdl_x  in  1  write PDL[index]
destpdlp  in  1  load pointer from ob[ADDR_W-1:0]
destpdlx  in  1  load index from ob[ADDR_W-1:0]
ob  in  DATA_W  destination data
pdl_addr  out  ADDR_W  RAM address
pdl_we  out  1  RAM write enable
pdl_wdata  out  DATA_W  RAM write data
pdl_rdata  in  DATA_W  RAM read data, synchronous, 1-cycle latency
pdl_q  out  DATA_W  source result, valid the cycle after step
pdlptr  out  ADDR_W  current pointer
pdlidx  out  ADDR_W  current index
stall  out  1  step must be held; RAM port busy
dbg_req  in  1  debug access request, held until dbg_ack
dbg_we  in  1  debug write
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  debug read data, valid with dbg_ack
pdl_err  out  1  sticky wrap error (optional feature)

Behaviour:
- Reset (async, reset_n=0): pdlptr=0, pdlidx=0, write buffer empty, FSM=IDLE. All outputs 0.
- Effective step: step & ~stall. Decoder guarantees at most one src* and one dest* per instruction.
- Source address:
  - srcpdlpop: old pointer.
  - srcpdltop: index.
- Pointer update on effective step (all arithmetic modulo 2^ADDR_W):
  - srcpdlpop: ptr-1.
  - destpdl_p: ptr+1.
  - Both in the same step: net pointer unchanged; write address = old pointer.
  - destpdlp: loads ptr and overrides both push and pop.
- Write buffer:
  - Any PDL-data destination captures {addr, ob} into the buffer at effective step.
  - The buffer drains to RAM on the next cycle in which microcode issues no read.
  - If the buffer is full at a new dest, drain takes the port that cycle and stall=1 for one cycle.
- Bypass: if a source read address equals a valid buffered address, pdl_q = buffered data. RAM data is ignored.
- pdl_q takes, in priority order:
  - the ptr/idx value when the source is srcpdlptr or srcpdlidx;
  - otherwise the bypass result or pdl_rdata;
  - otherwise 0.
- Debug FSM:
  - IDLE: dbg_req & ~step & buffer empty → DBG.
    - Drive dbg_addr.
    - Assert pdl_we = dbg_we.
    - Debug write updating a buffered address invalidates the buffer entry.
  - DBG → ACK: dbg_ack=1 and dbg_rdata = pdl_rdata.
  - ACK → IDLE once dbg_req drops.
  - step arriving in DBG: stall=1 for that cycle. Microcode has priority in IDLE.
- Reset mid-debug access: FSM returns to IDLE, no ack is issued, and the pending buffered write is lost.

Optional Feature:
- Macro: PDL_BOUNDS_TRAP_EN.
- Defined:
  - pdl_err is set on push wrap (ptr 2^ADDR_W-1 → 0) or pop wrap (0 → 2^ADDR_W-1).
  - Cleared by destpdlp or reset.
  - Wrap arithmetic itself is unchanged.
- Undefined: pdl_err tied 0; no extra logic.

Test Plan:
- Reset, destpdlp ob=5; destpdl_p ob=0xAA; srcpdlpop next step → pdl_q=0xAA one cycle later (bypass), pdlptr=5.
- destpdlx ob=0x3FF; destpdl_x ob=0x1234; idle cycle; srcpdltop → pdl_addr=0x3FF, pdl_q=0x1234 from RAM.
- Back-to-back destpdl_p ×2 with no intervening idle cycle → stall=1 exactly one cycle; RAM shows both words at ptr+1 and ptr+2.
- Ptr=0, srcpdlpop → pdlptr=0x3FF. With PDL_BOUNDS_TRAP_EN, pdl_err=1 until destpdlp.
- dbg_req write addr=7 data=0x55 while step=0 → dbg_ack after 2 cycles. Then srcpdltop with idx=7 → pdl_q=0x55.
- step asserted during DBG → stall=1, debug completes first, instruction executes the following cycle.
